lsu_initiator: RTL and testbench

Load/store unit bridging the CPU memory stage to a word-addressed data memory. Accepts one byte/half/word load or store per handshake, issues word-aligned memory transactions with byte enables, and on loads returns aligned, sign- or zero-extended data. Misaligned accesses are split into two word transactions (optional), and a watchdog aborts transactions the memory never acknowledges.

---
 rtl/lsu_initiator.sv | 249 ++++++++++++++++++++++++
 tb/tb_lsu_initiator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_initiator.sv
// lsu_initiator: load/store unit between the CPU memory stage and a word-addressed data memory.
//
// Accepts one byte/half/word load or store per req_valid/req_ready handshake. It issues
// word-aligned memory transactions with byte enables and lane-aligned write data. Loads
// return the addressed bytes right-justified and sign- or zero-extended. A watchdog aborts
// any transaction that is not acknowledged within TIMEOUT_CYCLES cycles (0 disables it).
//
// Build option: define LSU_MISALIGNED_EN to split misaligned accesses into two word
// transactions. Without it, misaligned accesses complete at once with rsp_err=1 and never
// touch memory.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  CPU request handshake (ready only while idle)
//   req_we               1 = store, 0 = load
//   req_funct3           000 b, 001 h, 010 w, 100 bu, 101 hu; other codes = word
//   req_addr, req_wdata  byte address and LSB-justified store data
//   rsp_valid            one-cycle completion pulse
//   rsp_rdata, rsp_err   extended load data (0 for stores/errors), error flag
//   mem_req, mem_we      memory transaction active, write strobe
//   mem_addr, mem_be     word address and byte enables
//   mem_wdata            lane-aligned write data
//   mem_rdata, mem_ack   read word and completion from memory
// All outputs are registered.
module lsu_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

`ifdef LSU_MISALIGNED_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [7:0]  mask_q, mask_d;
  logic [63:0] data_q, data_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] cnt_q, cnt_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  // Request decode, only meaningful in the acceptance cycle.
  logic [3:0]  size_be;
  logic [7:0]  acc_mask;
  logic [63:0] acc_data;
  logic        misaligned;
  logic        timeout;

  always_comb begin
    unique case (req_funct3[1:0])
      2'b00:   size_be = 4'b0001;
      2'b01:   size_be = 4'b0011;
      default: size_be = 4'b1111;
    endcase
    acc_mask   = {4'b0000, size_be} << req_addr[1:0];
    acc_data   = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    misaligned = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
                 (req_funct3[1] && (req_addr[1:0] != 2'b00));
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

  // Shift the two captured words down to the access offset, then truncate and extend.
  function automatic logic [31:0] extend(input logic [63:0] word, input logic [1:0] off,
                                         input logic [2:0] funct3);
    logic [31:0] sh;
    sh = 32'(word >> {off, 3'b000});
    case (funct3)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend = {24'h0, sh[7:0]};
      3'b101:  extend = {16'h0, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mask_d      = mask_q;
    data_d      = data_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 32'h0;
    mem_be_d    = 4'h0;
    mem_wdata_d = 32'h0;

    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          funct3_d    = req_funct3;
          off_d       = req_addr[1:0];
          mask_d      = acc_mask;
          data_d      = acc_data;
          if (misaligned && !SplitEn) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = StAcc0;
            cnt_d       = 32'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = acc_mask[3:0];
            mem_wdata_d = acc_data[31:0];
          end
        end
      end

      StAcc0, StAcc1: begin
        if (mem_ack) begin
          if ((state_q == StAcc0) && (mask_q[7:4] != 4'h0)) begin
            // Second word of a split access; mem_req stays high, the add wraps at 2^32.
            lo_d        = mem_rdata;
            state_d     = StAcc1;
            cnt_d       = 32'h0;
            mem_req_d   = 1'b1;
            mem_we_d    = we_q;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = mask_q[7:4];
            mem_wdata_d = data_q[63:32];
          end else begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            if (!we_q) begin
              // Single-word accesses only use bytes of the low word.
              rsp_rdata_d = (state_q == StAcc0) ? extend({32'h0, mem_rdata}, off_q, funct3_q)
                                                : extend({mem_rdata, lo_q}, off_q, funct3_q);
            end
          end
        end else if (timeout) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d       = cnt_q + 32'd1;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_addr_d  = mem_addr_q;
          mem_be_d    = mem_be_q;
          mem_wdata_d = mem_wdata_q;
        end
      end

      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'h0;
      off_q       <= 2'h0;
      mask_q      <= 8'h0;
      data_q      <= 64'h0;
      lo_q        <= 32'h0;
      cnt_q       <= 32'h0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_initiator.sv
// Testbench for lsu_initiator: directed vector table, watchdog and reset corner cases, then
// randomized requests against a byte-level memory model with random memory latency.
module tb_lsu_initiator;

`ifdef LSU_MISALIGNED_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  localparam int unsigned Timeout = 16;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  lsu_initiator #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          ntx;
    logic [31:0] a0, a1;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1;
  } exp_t;

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    exp_t        e;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          waits;
  } tx_t;

  logic [31:0] mem_words [logic [31:0]];
  tx_t         log_q [$];
  bit          ack_en = 1'b1;
  bit          noise = 1'b0;
  int          lat_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = rd_word(a & 32'hFFFF_FFFC);
    return w[8 * int'(a[1:0]) +: 8];
  endfunction

  // Byte-level reference: which bytes an access touches, where store bytes land, and what
  // value a load gathers from the memory model.
  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t        e;
    int          n, off;
    logic [31:0] v;
    logic [7:0]  b;
    e = '{default: 0};
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    if (((n == 2 && off == 3) || (n == 4 && off != 0)) && !SPLIT) begin
      e.err = 1'b1;
      return e;
    end
    e.a0 = addr & 32'hFFFF_FFFC;
    e.a1 = e.a0 + 32'd4;
    e.ntx = (off + n > 4) ? 2 : 1;
    for (int k = 0; k < 8; k++) begin
      if (k >= off && k < off + n) begin
        if (k < 4) e.be0[k] = 1'b1;
        else e.be1[k-4] = 1'b1;
      end
      if (k >= off && k - off < 4) begin
        b = wdata[8*(k-off) +: 8];
        if (k < 4) e.wd0[8*k +: 8] = b;
        else e.wd1[8*(k-4) +: 8] = b;
      end
    end
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mem_byte(addr + 32'(i));
      if (f3 == 3'b000 && v[7]) v[31:8] = '1;
      if (f3 == 3'b001 && v[15]) v[31:16] = '1;
      e.rdata = v;
    end
    return e;
  endfunction

  // Memory responder: acks after a random wait, logs each completed transaction and checks
  // that the request stays stable while waiting.
  int          wait_cnt = 0;
  int          cur_lat = 0;
  bit          have_prev = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_be;
  logic        prev_we;

  always @(negedge clk) begin
    logic [31:0] w;
    logic [31:0] m;
    if (rst) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
      have_prev = 1'b0;
    end else if (mem_req) begin
      if (have_prev) begin
        check("stable_addr", mem_addr, prev_addr);
        check("stable_be", 32'(mem_be), 32'(prev_be));
        check("stable_we", 32'(mem_we), 32'(prev_we));
        check("stable_wdata", mem_wdata, prev_wdata);
      end
      prev_addr = mem_addr; prev_be = mem_be; prev_we = mem_we; prev_wdata = mem_wdata;
      have_prev = 1'b1;
      if (ack_en && wait_cnt >= cur_lat) begin
        w = rd_word(mem_addr);
        mem_rdata = w;
        mem_ack = 1'b1;
        if (mem_we) begin
          m = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
          mem_words[mem_addr] = (w & ~m) | (mem_wdata & m);
        end
        log_q.push_back('{mem_addr, mem_be, mem_we, mem_wdata, wait_cnt});
        wait_cnt = 0;
        cur_lat = (lat_max > 0) ? $urandom_range(0, lat_max) : 0;
        have_prev = 1'b0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = noise ? 1'($urandom) : 1'b0;
      mem_rdata = $urandom;
      wait_cnt = 0;
      have_prev = 1'b0;
    end
  end

  // Issue one request (called at a negedge with req_ready high) and check the response,
  // the logged memory transactions and the timing. exp_cyc/exp_req < 0 derive the expected
  // cycle counts from the waits the memory actually inserted.
  task automatic apply(input string tag, input bit we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input exp_t e,
                       input int exp_cyc, input int exp_req);
    int cyc, reqc, wsum;
    log_q.delete();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check($sformatf("%s_busy", tag), 32'(req_ready), 32'h0);
    cyc = 1;
    reqc = 0;
    while (!rsp_valid && cyc < 200) begin
      if (mem_req) reqc++;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s_rsp_seen", tag), 32'(rsp_valid), 32'h1);
    check($sformatf("%s_err", tag), 32'(rsp_err), 32'(e.err));
    check($sformatf("%s_rdata", tag), rsp_rdata, e.rdata);
    @(negedge clk);
    check($sformatf("%s_pulse", tag), 32'(rsp_valid), 32'h0);
    check($sformatf("%s_ready", tag), 32'(req_ready), 32'h1);
    check($sformatf("%s_ntx", tag), 32'(log_q.size()), 32'(e.ntx));
    wsum = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      wsum += 1 + log_q[i].waits;
      check($sformatf("%s_we%0d", tag, i), 32'(log_q[i].we), 32'(we));
      if (i < 2) begin
        check($sformatf("%s_addr%0d", tag, i), log_q[i].addr, (i == 0) ? e.a0 : e.a1);
        check($sformatf("%s_be%0d", tag, i), 32'(log_q[i].be), 32'((i == 0) ? e.be0 : e.be1));
        check($sformatf("%s_wd%0d", tag, i), log_q[i].wdata, (i == 0) ? e.wd0 : e.wd1);
      end
    end
    if (exp_req < 0) exp_req = wsum;
    if (exp_cyc < 0) exp_cyc = 1 + wsum;
    check($sformatf("%s_req_cycles", tag), 32'(reqc), 32'(exp_req));
    check($sformatf("%s_rsp_cycles", tag), 32'(cyc), 32'(exp_cyc));
  endtask

  vec_t tbl [13];

  initial begin
    exp_t err_e, e;
    int   nrsp;
    bit          r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata;

    err_e = '{default: 0};
    err_e.err = 1'b1;

    tbl[0]  = '{1'b0, 3'b001, 32'h202, 32'h0,
                '{1'b0, 32'hFFFF_8001, 1, 32'h200, 32'h204, 4'b1100, 4'b0, 32'h0, 32'h0}, 2};
    tbl[1]  = '{1'b0, 3'b101, 32'h202, 32'h0,
                '{1'b0, 32'h0000_8001, 1, 32'h200, 32'h204, 4'b1100, 4'b0, 32'h0, 32'h0}, 2};
    if (SPLIT)
      tbl[2] = '{1'b0, 3'b010, 32'h103, 32'h0,
                 '{1'b0, 32'h7766_5544, 2, 32'h100, 32'h104, 4'b1000, 4'b0111, 32'h0, 32'h0}, 3};
    else
      tbl[2] = '{1'b0, 3'b010, 32'h103, 32'h0, err_e, 1};
    if (SPLIT)
      tbl[3] = '{1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF,
                 '{1'b0, 32'h0, 2, 32'hFFFF_FFFC, 32'h0, 4'b1000, 4'b0001,
                   32'hEF00_0000, 32'h0000_00BE}, 3};
    else
      tbl[3] = '{1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, err_e, 1};
    tbl[4]  = '{1'b0, 3'b000, 32'h101, 32'h0,
                '{1'b0, 32'h0000_0022, 1, 32'h100, 32'h104, 4'b0010, 4'b0, 32'h0, 32'h0}, 2};
    tbl[5]  = '{1'b0, 3'b000, 32'h107, 32'h0,
                '{1'b0, 32'hFFFF_FF88, 1, 32'h104, 32'h108, 4'b1000, 4'b0, 32'h0, 32'h0}, 2};
    tbl[6]  = '{1'b0, 3'b100, 32'h107, 32'h0,
                '{1'b0, 32'h0000_0088, 1, 32'h104, 32'h108, 4'b1000, 4'b0, 32'h0, 32'h0}, 2};
    tbl[7]  = '{1'b0, 3'b011, 32'h104, 32'h0,
                '{1'b0, 32'h8877_6655, 1, 32'h104, 32'h108, 4'b1111, 4'b0, 32'h0, 32'h0}, 2};
    tbl[8]  = '{1'b1, 3'b000, 32'h102, 32'h0000_00A5,
                '{1'b0, 32'h0, 1, 32'h100, 32'h104, 4'b0100, 4'b0, 32'h00A5_0000, 32'h0}, 2};
    tbl[9]  = '{1'b0, 3'b010, 32'h100, 32'h0,
                '{1'b0, 32'h44A5_2211, 1, 32'h100, 32'h104, 4'b1111, 4'b0, 32'h0, 32'h0}, 2};
    tbl[10] = '{1'b1, 3'b010, 32'h0, 32'hCAFE_F00D,
                '{1'b0, 32'h0, 1, 32'h0, 32'h4, 4'b1111, 4'b0, 32'hCAFE_F00D, 32'h0}, 2};
    tbl[11] = '{1'b0, 3'b101, 32'h2, 32'h0,
                '{1'b0, 32'h0000_CAFE, 1, 32'h0, 32'h4, 4'b1100, 4'b0, 32'h0, 32'h0}, 2};
    if (SPLIT)
      tbl[12] = '{1'b1, 3'b010, 32'h202, 32'h1122_3344,
                  '{1'b0, 32'h0, 2, 32'h200, 32'h204, 4'b1100, 4'b0011,
                    32'h3344_0000, 32'h0000_1122}, 3};
    else
      tbl[12] = '{1'b1, 3'b010, 32'h202, 32'h1122_3344, err_e, 1};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_err", 32'(rsp_err), 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_mem_we", 32'(mem_we), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_be", 32'(mem_be), 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    mem_words[32'h100] = 32'h4433_2211;
    mem_words[32'h104] = 32'h8877_6655;
    mem_words[32'h200] = 32'h8001_1234;
    noise = 1'b1;

    for (int i = 0; i < 13; i++)
      apply($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
            tbl[i].e, tbl[i].cyc, -1);

    // Watchdog: memory never acks.
    ack_en = 1'b0;
    apply("wdog", 1'b0, 3'b010, 32'h200, 32'h0, err_e, Timeout + 1, Timeout);
    ack_en = 1'b1;

    // Reset during ACC0 discards the access.
    ack_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h200;
    req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_mem_req", 32'(mem_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    ack_en = 1'b1;
    nrsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    check("rst_no_rsp", 32'(nrsp), 32'h0);

    // Random requests with random memory latency.
    lat_max = 3;
    for (int i = 0; i < 250; i++) begin
      r_we = 1'($urandom);
      r_f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) r_addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else r_addr = 32'h300 + 32'($urandom_range(0, 31));
      r_wdata = $urandom;
      e = model(r_we, r_f3, r_addr, r_wdata);
      apply($sformatf("rnd%0d", i), r_we, r_f3, r_addr, r_wdata, e, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
